mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_pkg.sv | 16 +
 rtl/rise_detect.sv | 23 ++
 rtl/mult_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the add/shift multiply sequencer.
package mult_pkg;

    // Default operand width, which is also the number of add/shift iterations.
    localparam int N_BITS_DEFAULT = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronized button level.
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic D,
    output logic Rise
);

    logic d_q;

    // Remember last cycle's level; it resets high so a level held across reset is not a rise.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= D;
        end
    end

    assign Rise = D & ~d_q;

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a signed add/shift multiplier (X:A:B datapath).
// Runs N_BITS add/shift iterations, subtracting on the final one.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N_BITS       = N_BITS_DEFAULT,
    parameter bit CLEAR_ON_RUN = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      ClearA_LoadB,
    input  logic                      M,
    output logic                      Clear_XA,
    output logic                      Load_B,
    output logic                      Load_A,
    output logic                      Sub,
    output logic                      Shift_En,
    output logic                      Busy,
    output logic                      Done,
    output logic [$clog2(N_BITS)-1:0] Step
);

    localparam int                 STEP_W    = $clog2(N_BITS);
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(N_BITS - 1);

    state_t state;
    logic   run_rise;

    rise_detect u_run_rise (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (Run),
        .Rise  (run_rise)
    );

    // State and iteration counter: one pass through ADD/SHIFT per multiplier bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            Step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The clear/load button wins over a run edge in the same cycle.
                    if (!ClearA_LoadB && run_rise) begin
                        Step  <= '0;
                        state <= CLEAR_ON_RUN ? CLR : ADD;
                    end
                end
                CLR: begin
                    state <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (Step == LAST_STEP) begin
                        state <= HOLD;
                    end else begin
                        Step  <= Step + 1'b1;
                        state <= ADD;
                    end
                end
                HOLD: begin
                    // Wait for the button to be released so a held Run cannot restart.
                    if (!Run) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decode datapath controls from state, Step, M and the buttons; all forced low in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        Clear_XA = 1'b0;
        Load_B   = 1'b0;
        Load_A   = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    Clear_XA = ClearA_LoadB;
                    Load_B   = ClearA_LoadB;
                end
                CLR: begin
                    Clear_XA = 1'b1;
                    Busy     = 1'b1;
                end
                ADD: begin
                    // The sign bit of B carries negative weight, hence subtract on the last step.
                    Load_A = M;
                    Sub    = M && (Step == LAST_STEP);
                    Busy   = 1'b1;
                end
                SHIFT: begin
                    Shift_En = 1'b1;
                    Busy     = 1'b1;
                end
                HOLD: begin
                    Done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
